memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 valid_in  input  1  execute-stage result valid this cycle.
REQ-005 alu_result  input  32  effective address, or non-memory result.
REQ-006 rs2E  input  32  store source data.
REQ-007 write_regE  input  1  instruction writes the register file.
REQ-008 info_loadE  input  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 treated as none.
REQ-009 info_storeE  input  2  0 none, 1 SB, 2 SH, 3 SW.
REQ-010 dstreg_addrE  input  5  destination register index.
REQ-011 stall  output  1  upstream SHALL hold its outputs while this is 1.
REQ-012 mem_req  output  1  data-memory request.
REQ-013 mem_we  output  1  1 = write, 0 = read.
REQ-014 mem_addr  output  32  word address: {alu_result[31:2], 2'b00}.
REQ-015 mem_be  output  4  byte enables; bit n = byte lane n.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_rdata  input  32  read data, valid when mem_ack is 1.
REQ-018 mem_ack  input  1  one-cycle completion pulse.
REQ-019 valid_out  output  1  one-cycle pulse: writeback outputs valid.
REQ-020 wb_data  output  32  writeback data.
REQ-021 write_regM  output  1  register write enable to writeback.
REQ-022 dstreg_addrM  output  5  destination index to writeback.
REQ-023 misalign_err  output  1  pulses with valid_out for a misaligned access.

Function
REQ-024 FSM states SHALL be IDLE and WAIT; stall SHALL be 1 exactly when the state is WAIT.
REQ-025 In IDLE with valid_in=1, the block SHALL capture all inputs at the clock edge.
REQ-026 A non-memory operation SHALL go to the outputs on the next cycle: valid_out=1, wb_data=alu_result, write_regM=write_regE, dstreg_addrM=dstreg_addrE.
REQ-027 If info_loadE and info_storeE are both non-zero, the operation SHALL be treated as a load and the store ignored.
REQ-028 An aligned load or store SHALL move the FSM to WAIT.
- mem_req=1 for the whole WAIT state.
- mem_addr, mem_we, mem_be and mem_wdata stable for the whole WAIT state.
REQ-029 Load byte enables SHALL be 4'b1111 with mem_we=0.
REQ-030 Store byte enables and data:
- SB: mem_be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
- SH: mem_be = 4'b0011 if addr[1]=0, else 4'b1100; wdata = halfword replicated x2.
- SW: mem_be = 4'b1111.
- All stores: mem_we=1.
REQ-031 In WAIT, mem_ack SHALL be sampled each cycle; inputs SHALL be ignored.
REQ-032 On the edge where mem_ack=1 in WAIT, the FSM SHALL return to IDLE, deassert mem_req, and pulse valid_out the following cycle.
REQ-033 Load data SHALL be taken from mem_rdata using the captured addr[1:0].
- LB/LH: sign-extended; LBU/LHU: zero-extended; LW: full word.
REQ-034 For a store, write_regM SHALL be 0 and wb_data SHALL be 0.
REQ-035 Alignment rules:
- LH/LHU/SH require addr[0]=0.
- LW/SW require addr[1:0]=0.
REQ-036 A misaligned access SHALL NOT issue mem_req; it SHALL complete in one cycle with valid_out=1, misalign_err=1, write_regM=0.
REQ-037 mem_ack while in IDLE SHALL be ignored.
REQ-038 valid_out, misalign_err and write_regM SHALL be 0 in every cycle that has no completion.
REQ-039 Minimum latency:
- Non-memory operation: 1 cycle.
- Memory operation: 2 cycles + memory wait cycles.
- Back-to-back non-memory operations: 1 per cycle.

Reset
REQ-040 While rst_n=0, all outputs SHALL be 0 and the FSM SHALL be IDLE, asynchronously.
REQ-041 Reset during WAIT SHALL abandon the transaction: mem_req drops immediately and no valid_out follows.
REQ-042 After rst_n rises, the first capture SHALL occur at the first clock edge with valid_in=1.

Verification
REQ-043 ALU pass-through: valid_in, alu_result=0x1234, write_regE=1, dstreg=5 -> next cycle valid_out=1, wb_data=0x1234, dstreg_addrM=5; stall=0.
REQ-044 Sign-extending load: LB at addr 0x103, mem_rdata=0x80FF_FF00, ack after 3 WAIT cycles -> stall=1 for 3 cycles, mem_addr=0x100, wb_data=0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-045 Halfword store: SH at addr 0x202, rs2E=0xDEAD_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, write_regM=0.
REQ-046 Misaligned load: LW at addr 0x301 -> no mem_req, next cycle valid_out=1, misalign_err=1, write_regM=0.
REQ-047 Reset mid-operation: rst_n=0 during WAIT -> mem_req=0 at once; after release, mem_ack=1 produces no valid_out.
REQ-048 Back-to-back: ALU op, then SW, then ALU op with mem_ack on the first WAIT cycle -> three valid_out pulses in order; the third op is held by stall until the store completes.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: forwards ALU results, issues aligned loads/stores to a
// handshaked data memory, and formats load data for writeback.
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM,
  output logic        misalign_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_capture;
  logic        w_complete;
  logic        w_isLoad;
  logic        w_isStore;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [3:0]  r_memBe;
  logic [31:0] r_memWdata;
  logic [2:0]  r_loadType;
  logic [1:0]  r_addrLow;
  logic        r_writeReg;
  logic [4:0]  r_dst;
  logic        r_validOut;
  logic [31:0] r_wbData;
  logic        r_writeRegM;
  logic [4:0]  r_dstM;
  logic        r_misalign;

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_isLoad    = (info_loadE != 3'd0) && (info_loadE <= 3'd5);
    w_isStore   = !w_isLoad && (info_storeE != 2'd0);
    w_misalign  = 1'b0;
    w_be        = 4'b1111;
    w_wdata     = rs2E;
    w_byte      = 8'd0;
    w_half      = 16'd0;
    w_loadData  = 32'd0;

    if (w_isLoad) begin
      case (info_loadE)
        3'd2, 3'd5: w_misalign = alu_result[0];
        3'd3:       w_misalign = |alu_result[1:0];
        default:    w_misalign = 1'b0;
      endcase
    end else if (w_isStore) begin
      case (info_storeE)
        2'd2:    w_misalign = alu_result[0];
        2'd3:    w_misalign = |alu_result[1:0];
        default: w_misalign = 1'b0;
      endcase
    end

    // Store lanes: narrow data is replicated so every enabled lane carries it.
    case (info_storeE)
      2'd1: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{rs2E[7:0]}};
      end
      2'd2: begin
        w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{rs2E[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = rs2E;
      end
    endcase

    case (r_addrLow)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addrLow[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (r_loadType)
      3'd1:    w_loadData = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_loadData = {{16{w_half[15]}}, w_half};
      3'd3:    w_loadData = mem_rdata;
      3'd4:    w_loadData = {24'd0, w_byte};
      3'd5:    w_loadData = {16'd0, w_half};
      default: w_loadData = 32'd0;
    endcase

    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_capture = 1'b1;
          if ((w_isLoad || w_isStore) && !w_misalign) w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          w_complete  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Completion flags default low so every result is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memWe     <= 1'b0;
      r_memAddr   <= 32'd0;
      r_memBe     <= 4'd0;
      r_memWdata  <= 32'd0;
      r_loadType  <= 3'd0;
      r_addrLow   <= 2'd0;
      r_writeReg  <= 1'b0;
      r_dst       <= 5'd0;
      r_validOut  <= 1'b0;
      r_wbData    <= 32'd0;
      r_writeRegM <= 1'b0;
      r_dstM      <= 5'd0;
      r_misalign  <= 1'b0;
    end else begin
      r_validOut  <= 1'b0;
      r_writeRegM <= 1'b0;
      r_misalign  <= 1'b0;
      if (w_capture) begin
        if (!(w_isLoad || w_isStore)) begin
          r_validOut  <= 1'b1;
          r_wbData    <= alu_result;
          r_writeRegM <= write_regE;
          r_dstM      <= dstreg_addrE;
        end else if (w_misalign) begin
          r_validOut <= 1'b1;
          r_misalign <= 1'b1;
          r_wbData   <= 32'd0;
          r_dstM     <= dstreg_addrE;
        end else begin
          r_memAddr  <= {alu_result[31:2], 2'b00};
          r_memWe    <= w_isStore;
          r_memBe    <= w_isLoad ? 4'b1111 : w_be;
          r_memWdata <= w_isStore ? w_wdata : 32'd0;
          r_loadType <= w_isLoad ? info_loadE : 3'd0;
          r_addrLow  <= alu_result[1:0];
          r_writeReg <= write_regE;
          r_dst      <= dstreg_addrE;
        end
      end else if (w_complete) begin
        r_validOut  <= 1'b1;
        r_wbData    <= w_loadData;
        r_writeRegM <= (r_loadType != 3'd0) && r_writeReg;
        r_dstM      <= r_dst;
      end
    end
  end

  assign stall        = (r_state == WAIT);
  assign mem_req      = (r_state == WAIT);
  assign mem_we       = r_memWe;
  assign mem_addr     = r_memAddr;
  assign mem_be       = r_memBe;
  assign mem_wdata    = r_memWdata;
  assign valid_out    = r_validOut;
  assign wb_data      = r_wbData;
  assign write_regM   = r_writeRegM;
  assign dstreg_addrM = r_dstM;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: pass-through, loads, stores,
// misalignment, reset abandonment and back-to-back sequencing.
module tb_memory_access;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] rs2E;
  logic        write_regE;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        valid_out;
  logic [31:0] wb_data;
  logic        write_regM;
  logic [4:0]  dstreg_addrM;
  logic        misalign_err;

  int vectors = 0;
  int miscompares = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
    .rs2E(rs2E), .write_regE(write_regE), .info_loadE(info_loadE),
    .info_storeE(info_storeE), .dstreg_addrE(dstreg_addrE), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid_out(valid_out), .wb_data(wb_data), .write_regM(write_regM),
    .dstreg_addrM(dstreg_addrM), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] ld,
                          input logic [1:0] st, input logic wr, input logic [4:0] dst);
    valid_in = 1'b1; alu_result = addr; rs2E = data; info_loadE = ld;
    info_storeE = st; write_regE = wr; dstreg_addrE = dst;
  endtask

  task automatic drive_idle();
    valid_in = 1'b0; info_loadE = 3'd0; info_storeE = 2'd0; write_regE = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive_idle(); alu_result = 32'hFFFF_FFFF; rs2E = 32'hFFFF_FFFF;
    dstreg_addrE = 5'd31; mem_rdata = 32'd0;
    #3;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %0h want 0", stall); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %0h want 0", mem_req); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0h want 0", valid_out); end
    vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_wb: got %h want 0", wb_data); end
    vectors++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin miscompares++; $display("[TB] FAIL reset_memif: got %h want 0", {mem_we, mem_be, mem_addr, mem_wdata}); end
    vectors++; if ({write_regM, misalign_err, dstreg_addrM} !== 7'd0) begin miscompares++; $display("[TB] FAIL reset_wbctl: got %h want 0", {write_regM, misalign_err, dstreg_addrM}); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_pass();
    drive_op(32'h1234, 32'h0, 3'd0, 2'd0, 1'b1, 5'd5);
    step(); drive_idle();
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL alu_valid: got %0h want 1", valid_out); end
    vectors++; if (wb_data !== 32'h1234) begin miscompares++; $display("[TB] FAIL alu_wb: got %h want 00001234", wb_data); end
    vectors++; if (dstreg_addrM !== 5'd5) begin miscompares++; $display("[TB] FAIL alu_dst: got %0d want 5", dstreg_addrM); end
    vectors++; if (write_regM !== 1'b1) begin miscompares++; $display("[TB] FAIL alu_wr: got %0h want 1", write_regM); end
    vectors++; if ({stall, mem_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL alu_stall: got %b want 00", {stall, mem_req}); end
    step();
    vectors++; if ({valid_out, write_regM} !== 2'b00) begin miscompares++; $display("[TB] FAIL alu_pulse: got %b want 00", {valid_out, write_regM}); end
  endtask

  task automatic test_loads();
    logic [2:0]  ldType [5] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3};
    logic [31:0] ldAddr [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
    logic [31:0] ldMem  [5] = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h80FF_FF00, 32'h80FF_FF00, 32'h1357_9BDF};
    logic [31:0] ldExp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h1357_9BDF};
    logic [31:0] ldWord [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
    for (int i = 0; i < 5; i++) begin
      drive_op(ldAddr[i], 32'h0, ldType[i], 2'd0, 1'b1, 5'(i + 7));
      step(); drive_idle();
      for (int w = 0; w < 3; w++) begin
        vectors++; if ({stall, mem_req, mem_we, valid_out} !== 4'b1100) begin miscompares++; $display("[TB] FAIL load%0d_wait%0d: got %b want 1100", i, w, {stall, mem_req, mem_we, valid_out}); end
        vectors++; if ({mem_addr, mem_be} !== {ldWord[i], 4'b1111}) begin miscompares++; $display("[TB] FAIL load%0d_addr: got %h/%b want %h/1111", i, mem_addr, mem_be, ldWord[i]); end
        if (w == 2) begin mem_ack = 1'b1; mem_rdata = ldMem[i]; end
        step();
      end
      mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
      vectors++; if ({valid_out, write_regM, stall, mem_req} !== 4'b1100) begin miscompares++; $display("[TB] FAIL load%0d_done: got %b want 1100", i, {valid_out, write_regM, stall, mem_req}); end
      vectors++; if (wb_data !== ldExp[i]) begin miscompares++; $display("[TB] FAIL load%0d_data: got %h want %h", i, wb_data, ldExp[i]); end
      vectors++; if (dstreg_addrM !== 5'(i + 7)) begin miscompares++; $display("[TB] FAIL load%0d_dst: got %0d want %0d", i, dstreg_addrM, i + 7); end
      step();
    end
  endtask

  task automatic test_stores();
    logic [31:0] stAddr [4] = '{32'h202, 32'h401, 32'h50C, 32'h500};
    logic [31:0] stData [4] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_F00D};
    logic [2:0]  stLoad [4] = '{3'd0, 3'd0, 3'd0, 3'd3};
    logic [1:0]  stKind [4] = '{2'd2, 2'd1, 2'd3, 2'd3};
    logic [31:0] expAddr[4] = '{32'h200, 32'h400, 32'h50C, 32'h500};
    logic [3:0]  expBe  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1111};
    logic        expWe  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] expWd  [4] = '{32'hBEEF_BEEF, 32'h7878_7878, 32'hCAFE_F00D, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive_op(stAddr[i], stData[i], stLoad[i], stKind[i], 1'b1, 5'd9);
      step(); drive_idle();
      vectors++; if ({mem_req, mem_we} !== {1'b1, expWe[i]}) begin miscompares++; $display("[TB] FAIL store%0d_req: got %b want 1%b", i, {mem_req, mem_we}, expWe[i]); end
      vectors++; if ({mem_addr, mem_be} !== {expAddr[i], expBe[i]}) begin miscompares++; $display("[TB] FAIL store%0d_be: got %h/%b want %h/%b", i, mem_addr, mem_be, expAddr[i], expBe[i]); end
      if (expWe[i]) begin
        vectors++; if (mem_wdata !== expWd[i]) begin miscompares++; $display("[TB] FAIL store%0d_wdata: got %h want %h", i, mem_wdata, expWd[i]); end
      end
      mem_ack = 1'b1; mem_rdata = 32'h0000_0000;
      step(); mem_ack = 1'b0;
      vectors++; if ({valid_out, write_regM, stall} !== {1'b1, !expWe[i], 1'b0}) begin miscompares++; $display("[TB] FAIL store%0d_done: got %b want 1%b0", i, {valid_out, write_regM, stall}, !expWe[i]); end
      vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("[TB] FAIL store%0d_wb: got %h want 0", i, wb_data); end
      step();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] maAddr [3] = '{32'h301, 32'h203, 32'h105};
    logic [2:0]  maLoad [3] = '{3'd3, 3'd0, 3'd5};
    logic [1:0]  maStore[3] = '{2'd0, 2'd2, 2'd0};
    for (int i = 0; i < 3; i++) begin
      drive_op(maAddr[i], 32'h55, maLoad[i], maStore[i], 1'b1, 5'd12);
      step(); drive_idle();
      vectors++; if ({mem_req, stall} !== 2'b00) begin miscompares++; $display("[TB] FAIL mis%0d_req: got %b want 00", i, {mem_req, stall}); end
      vectors++; if ({valid_out, misalign_err, write_regM} !== 3'b110) begin miscompares++; $display("[TB] FAIL mis%0d_flags: got %b want 110", i, {valid_out, misalign_err, write_regM}); end
      step();
      vectors++; if ({valid_out, misalign_err, mem_req} !== 3'b000) begin miscompares++; $display("[TB] FAIL mis%0d_clear: got %b want 000", i, {valid_out, misalign_err, mem_req}); end
    end
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    mem_ack = 1'b0;
    vectors++; if ({valid_out, stall, mem_req} !== 3'b000) begin miscompares++; $display("[TB] FAIL ack_idle: got %b want 000", {valid_out, stall, mem_req}); end
  endtask

  task automatic test_reset_mid();
    drive_op(32'h600, 32'h0, 3'd3, 2'd0, 1'b1, 5'd3);
    step(); drive_idle();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_req: got %0h want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({mem_req, stall, valid_out} !== 3'b000) begin miscompares++; $display("[TB] FAIL rstmid_drop: got %b want 000", {mem_req, stall, valid_out}); end
    #3 rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step(); step();
    mem_ack = 1'b0;
    vectors++; if ({valid_out, write_regM, mem_req} !== 3'b000) begin miscompares++; $display("[TB] FAIL rstmid_novalid: got %b want 000", {valid_out, write_regM, mem_req}); end
  endtask

  task automatic test_back_to_back();
    drive_op(32'h11, 32'h0, 3'd0, 2'd0, 1'b1, 5'd1);
    step();
    drive_op(32'h700, 32'hCAFE_F00D, 3'd0, 2'd3, 1'b0, 5'd2);
    vectors++; if ({valid_out, wb_data, dstreg_addrM} !== {1'b1, 32'h11, 5'd1}) begin miscompares++; $display("[TB] FAIL b2b_first: got %b/%h/%0d want 1/00000011/1", valid_out, wb_data, dstreg_addrM); end
    step();
    drive_op(32'h33, 32'h0, 3'd0, 2'd0, 1'b1, 5'd3);
    mem_ack = 1'b1;
    vectors++; if ({stall, mem_req, mem_we, valid_out} !== 4'b1110) begin miscompares++; $display("[TB] FAIL b2b_wait: got %b want 1110", {stall, mem_req, mem_we, valid_out}); end
    step();
    mem_ack = 1'b0;
    vectors++; if ({valid_out, write_regM, stall, dstreg_addrM} !== {3'b100, 5'd2}) begin miscompares++; $display("[TB] FAIL b2b_store: got %b/%0d want 100/2", {valid_out, write_regM, stall}, dstreg_addrM); end
    step(); drive_idle();
    vectors++; if ({valid_out, write_regM, wb_data, dstreg_addrM} !== {2'b11, 32'h33, 5'd3}) begin miscompares++; $display("[TB] FAIL b2b_third: got %b%b/%h/%0d want 11/00000033/3", valid_out, write_regM, wb_data, dstreg_addrM); end
    step();
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_end: got %0h want 0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_loads();
    test_stores();
    test_misalign();
    test_ack_idle();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
